mode_scheduler: RTL and testbench

MODE_SCHEDULER -- requirements
Module: mode_scheduler

---
 rtl/mode_scheduler_pkg.sv | 14 +
 rtl/mode_scheduler_btn_edge.sv | 27 ++
 rtl/mode_scheduler.sv | 126 ++++++++++++
 tb/tb_mode_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mode_scheduler_pkg.sv
// Shared definitions for the mode scheduler: FSM state encoding and width constants.
package mode_scheduler_pkg;

   localparam int MODE_W           = 3;
   localparam int DEFAULT_NUM_MODE = 5;

   typedef enum logic [1:0] {
      ST_MENU,
      ST_LAUNCH,
      ST_RUN,
      ST_EXIT
   } state_t;

endpackage

// File: rtl/mode_scheduler_btn_edge.sv
// Rising-edge detector for one debounced button level; history clears on reset so a
// button already held when reset releases produces a single edge.
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic rise
);

   logic hist_q;
   logic hist_d;

   always_comb begin
      hist_d = level;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= 1'b0;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign rise = level & ~hist_q;

endmodule

// File: rtl/mode_scheduler.sv
// Menu/launch/run/exit sequencer that selects one of NUM_MODE mode blocks from button
// edges and drives registered enables, launch pulse and display select.
module mode_scheduler
   import mode_scheduler_pkg::*;
#(
   parameter int NUM_MODE    = DEFAULT_NUM_MODE,
   parameter int EXIT_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                preMode,
   input  logic                nextMode,
   input  logic                confirm,
   input  logic                back,
   input  logic [NUM_MODE-1:0] mode_done,
   output logic [MODE_W-1:0]   cursor,
   output logic [MODE_W-1:0]   active_mode,
   output logic [NUM_MODE-1:0] mode_en,
   output logic                mode_start,
   output logic                disp_sel,
   output logic                busy
);

   localparam int                 CNT_W     = (EXIT_CYCLES > 1) ? $clog2(EXIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]   EXIT_LAST = CNT_W'(EXIT_CYCLES - 1);
   localparam logic [MODE_W-1:0]  CUR_MAX   = MODE_W'(NUM_MODE - 1);

   logic pre_rise;
   logic next_rise;
   logic confirm_rise;
   logic back_rise;

   btn_edge u_pre_edge     (.clk(clk), .rst(rst), .level(preMode),  .rise(pre_rise));
   btn_edge u_next_edge    (.clk(clk), .rst(rst), .level(nextMode), .rise(next_rise));
   btn_edge u_confirm_edge (.clk(clk), .rst(rst), .level(confirm),  .rise(confirm_rise));
   btn_edge u_back_edge    (.clk(clk), .rst(rst), .level(back),     .rise(back_rise));

   state_t              state_q,       state_d;
   logic [MODE_W-1:0]   cursor_q,      cursor_d;
   logic [MODE_W-1:0]   active_mode_q, active_mode_d;
   logic [NUM_MODE-1:0] mode_en_q,     mode_en_d;
   logic                mode_start_q,  mode_start_d;
   logic                disp_sel_q,    disp_sel_d;
   logic                busy_q,        busy_d;
   logic [CNT_W-1:0]    exit_cnt_q,    exit_cnt_d;
   logic                done_hit;
   logic [NUM_MODE-1:0] mode_sel;

   always_comb begin
      state_d       = state_q;
      cursor_d      = cursor_q;
      active_mode_d = active_mode_q;
      exit_cnt_d    = exit_cnt_q;
      done_hit      = |(mode_done & (NUM_MODE'(1) << active_mode_q));

      case (state_q)
         ST_MENU: begin
            // Confirm outranks cursor movement; opposing cursor edges cancel out.
            if (confirm_rise) begin
               active_mode_d = cursor_q;
               state_d       = ST_LAUNCH;
            end else if (pre_rise && !next_rise) begin
               cursor_d = (cursor_q == CUR_MAX) ? '0 : cursor_q + 1'b1;
            end else if (next_rise && !pre_rise) begin
               cursor_d = (cursor_q == '0) ? CUR_MAX : cursor_q - 1'b1;
            end
         end
         ST_LAUNCH: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (back_rise || done_hit) begin
               state_d    = ST_EXIT;
               exit_cnt_d = '0;
            end
         end
         ST_EXIT: begin
            if (exit_cnt_q == EXIT_LAST) begin
               state_d = ST_MENU;
            end else begin
               exit_cnt_d = exit_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_MENU;
         end
      endcase

      // Outputs are decoded from the next state so every port comes straight from a flop.
      mode_sel     = NUM_MODE'(1) << active_mode_d;
      mode_en_d    = ((state_d == ST_LAUNCH) || (state_d == ST_RUN)) ? mode_sel : '0;
      mode_start_d = (state_d == ST_LAUNCH);
      disp_sel_d   = (state_d != ST_MENU);
      busy_d       = (state_d != ST_MENU);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_MENU;
         cursor_q      <= '0;
         active_mode_q <= '0;
         mode_en_q     <= '0;
         mode_start_q  <= 1'b0;
         disp_sel_q    <= 1'b0;
         busy_q        <= 1'b0;
         exit_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         cursor_q      <= cursor_d;
         active_mode_q <= active_mode_d;
         mode_en_q     <= mode_en_d;
         mode_start_q  <= mode_start_d;
         disp_sel_q    <= disp_sel_d;
         busy_q        <= busy_d;
         exit_cnt_q    <= exit_cnt_d;
      end
   end

   assign cursor      = cursor_q;
   assign active_mode = active_mode_q;
   assign mode_en     = mode_en_q;
   assign mode_start  = mode_start_q;
   assign disp_sel    = disp_sel_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_mode_scheduler.sv
// Self-checking bench for mode_scheduler: a table of per-cycle vectors checked through a
// scoreboard queue, then hand-written launch/exit timing sequences with bounded waits.
module tb_mode_scheduler;

   localparam int NUM_MODE = 5;

   logic                clk = 1'b0;
   logic                rst;
   logic                pre_mode;
   logic                next_mode;
   logic                confirm;
   logic                back;
   logic [NUM_MODE-1:0] mode_done;
   logic [2:0]          cursor;
   logic [2:0]          active_mode;
   logic [NUM_MODE-1:0] mode_en;
   logic                mode_start;
   logic                disp_sel;
   logic                busy;

   mode_scheduler #(.NUM_MODE(NUM_MODE), .EXIT_CYCLES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .preMode    (pre_mode),
      .nextMode   (next_mode),
      .confirm    (confirm),
      .back       (back),
      .mode_done  (mode_done),
      .cursor     (cursor),
      .active_mode(active_mode),
      .mode_en    (mode_en),
      .mode_start (mode_start),
      .disp_sel   (disp_sel),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]          cursor;
      logic [2:0]          active_mode;
      logic [NUM_MODE-1:0] mode_en;
      logic                mode_start;
      logic                disp_sel;
      logic                busy;
   } out_t;

   typedef struct {
      logic                rst;
      logic                pre;
      logic                nxt;
      logic                conf;
      logic                bck;
      logic [NUM_MODE-1:0] done;
      out_t                exp;
   } vec_t;

   vec_t vecs[$];
   out_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic addVec(input logic r, input logic p, input logic n, input logic c,
                         input logic b, input logic [NUM_MODE-1:0] d,
                         input logic [2:0] cur, input logic [2:0] act,
                         input logic [NUM_MODE-1:0] en, input logic st,
                         input logic ds, input logic bs);
      vec_t v;
      v.rst  = r;
      v.pre  = p;
      v.nxt  = n;
      v.conf = c;
      v.bck  = b;
      v.done = d;
      v.exp  = '{cursor: cur, active_mode: act, mode_en: en,
                 mode_start: st, disp_sel: ds, busy: bs};
      vecs.push_back(v);
   endtask

   // Drive one vector away from the edge, queue its expectation, then step past the edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      rst       = v.rst;
      pre_mode  = v.pre;
      next_mode = v.nxt;
      confirm   = v.conf;
      back      = v.bck;
      mode_done = v.done;
      sb_q.push_back(v.exp);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name);
      out_t got;
      out_t exp;
      got = '{cursor: cursor, active_mode: active_mode, mode_en: mode_en,
              mode_start: mode_start, disp_sel: disp_sel, busy: busy};
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL %s: scoreboard empty, nothing expected", name);
      end else begin
         exp = sb_q.pop_front();
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got cur=%0d act=%0d en=%b st=%b ds=%b bs=%b, want cur=%0d act=%0d en=%b st=%b ds=%b bs=%b",
                     name, got.cursor, got.active_mode, got.mode_en, got.mode_start,
                     got.disp_sel, got.busy, exp.cursor, exp.active_mode, exp.mode_en,
                     exp.mode_start, exp.disp_sel, exp.busy);
         end
      end
   endtask

   task automatic checkValue(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, got, exp);
      end
   endtask

   initial begin
      int lat;
      int exit_len;

      rst       = 1'b1;
      pre_mode  = 1'b0;
      next_mode = 1'b0;
      confirm   = 1'b0;
      back      = 1'b0;
      mode_done = '0;

      //      rst pre nxt cnf bck done      cur act en        st ds bs
      addVec(1, 0, 0, 0, 0, 5'b00000,  0, 0, 5'b00000, 0, 0, 0); // 0 reset
      addVec(1, 0, 0, 0, 0, 5'b00000,  0, 0, 5'b00000, 0, 0, 0);
      addVec(0, 0, 0, 0, 0, 5'b00000,  0, 0, 5'b00000, 0, 0, 0);
      addVec(0, 1, 0, 0, 0, 5'b00000,  1, 0, 5'b00000, 0, 0, 0); // cursor up
      addVec(0, 0, 0, 0, 0, 5'b00000,  1, 0, 5'b00000, 0, 0, 0);
      addVec(0, 1, 0, 0, 0, 5'b00000,  2, 0, 5'b00000, 0, 0, 0);
      addVec(0, 0, 0, 0, 0, 5'b00000,  2, 0, 5'b00000, 0, 0, 0);
      addVec(0, 1, 0, 0, 0, 5'b00000,  3, 0, 5'b00000, 0, 0, 0);
      addVec(0, 0, 0, 0, 0, 5'b00000,  3, 0, 5'b00000, 0, 0, 0);
      addVec(0, 1, 0, 0, 0, 5'b00000,  4, 0, 5'b00000, 0, 0, 0);
      addVec(0, 0, 0, 0, 0, 5'b00000,  4, 0, 5'b00000, 0, 0, 0); // 10
      addVec(0, 1, 0, 0, 0, 5'b00000,  0, 0, 5'b00000, 0, 0, 0); // wrap 4 -> 0
      addVec(0, 0, 0, 0, 0, 5'b00000,  0, 0, 5'b00000, 0, 0, 0);
      addVec(0, 0, 1, 0, 0, 5'b00000,  4, 0, 5'b00000, 0, 0, 0); // wrap 0 -> 4
      addVec(0, 0, 0, 0, 0, 5'b00000,  4, 0, 5'b00000, 0, 0, 0);
      addVec(0, 0, 1, 0, 0, 5'b00000,  3, 0, 5'b00000, 0, 0, 0);
      addVec(0, 0, 0, 0, 0, 5'b00000,  3, 0, 5'b00000, 0, 0, 0);
      addVec(0, 0, 1, 0, 0, 5'b00000,  2, 0, 5'b00000, 0, 0, 0);
      addVec(0, 0, 1, 0, 0, 5'b00000,  2, 0, 5'b00000, 0, 0, 0); // held level
      addVec(0, 0, 0, 0, 0, 5'b00000,  2, 0, 5'b00000, 0, 0, 0);
      addVec(0, 1, 1, 0, 0, 5'b00000,  2, 0, 5'b00000, 0, 0, 0); // 20 both edges cancel
      addVec(0, 0, 0, 0, 0, 5'b00000,  2, 0, 5'b00000, 0, 0, 0);
      addVec(0, 0, 0, 1, 0, 5'b00000,  2, 2, 5'b00100, 1, 1, 1); // launch
      addVec(0, 0, 0, 1, 0, 5'b00000,  2, 2, 5'b00100, 0, 1, 1); // run
      addVec(0, 1, 0, 0, 0, 5'b00000,  2, 2, 5'b00100, 0, 1, 1); // cursor ignored in run
      addVec(0, 0, 0, 0, 0, 5'b01000,  2, 2, 5'b00100, 0, 1, 1); // foreign done ignored
      addVec(0, 0, 0, 0, 0, 5'b00100,  2, 2, 5'b00000, 0, 1, 1); // own done -> exit
      addVec(0, 0, 0, 0, 0, 5'b00000,  2, 2, 5'b00000, 0, 1, 1);
      addVec(0, 0, 0, 0, 0, 5'b00000,  2, 2, 5'b00000, 0, 0, 0); // back in menu
      addVec(0, 0, 0, 0, 0, 5'b00000,  2, 2, 5'b00000, 0, 0, 0);
      addVec(0, 1, 0, 1, 0, 5'b00000,  2, 2, 5'b00100, 1, 1, 1); // 30 confirm beats preMode
      addVec(0, 0, 0, 0, 0, 5'b00000,  2, 2, 5'b00100, 0, 1, 1);
      addVec(0, 0, 0, 0, 1, 5'b00100,  2, 2, 5'b00000, 0, 1, 1); // back + done together
      addVec(0, 1, 0, 0, 0, 5'b00000,  2, 2, 5'b00000, 0, 1, 1); // preMode ignored in exit
      addVec(0, 0, 0, 0, 0, 5'b00000,  2, 2, 5'b00000, 0, 0, 0);
      addVec(0, 0, 0, 0, 0, 5'b00000,  2, 2, 5'b00000, 0, 0, 0);
      addVec(0, 0, 0, 1, 0, 5'b00000,  2, 2, 5'b00100, 1, 1, 1);
      addVec(0, 0, 0, 0, 0, 5'b00000,  2, 2, 5'b00100, 0, 1, 1);
      addVec(0, 0, 0, 0, 1, 5'b00000,  2, 2, 5'b00000, 0, 1, 1); // back aborts
      addVec(0, 0, 0, 0, 0, 5'b00000,  2, 2, 5'b00000, 0, 1, 1);
      addVec(0, 0, 0, 0, 0, 5'b00000,  2, 2, 5'b00000, 0, 0, 0); // 40
      addVec(0, 0, 1, 0, 0, 5'b00000,  1, 2, 5'b00000, 0, 0, 0);
      addVec(0, 0, 0, 1, 0, 5'b00000,  1, 1, 5'b00010, 1, 1, 1);
      addVec(0, 0, 0, 0, 0, 5'b00000,  1, 1, 5'b00010, 0, 1, 1);
      addVec(1, 0, 0, 0, 0, 5'b00000,  0, 0, 5'b00000, 0, 0, 0); // reset during run
      addVec(0, 0, 0, 0, 0, 5'b00000,  0, 0, 5'b00000, 0, 0, 0);
      addVec(1, 1, 0, 0, 0, 5'b00000,  0, 0, 5'b00000, 0, 0, 0); // button held in reset
      addVec(0, 1, 0, 0, 0, 5'b00000,  1, 0, 5'b00000, 0, 0, 0); // one edge after reset
      addVec(0, 1, 0, 0, 0, 5'b00000,  1, 0, 5'b00000, 0, 0, 0);
      addVec(0, 0, 0, 0, 0, 5'b00000,  1, 0, 5'b00000, 0, 0, 0);
      addVec(0, 0, 0, 1, 0, 5'b00000,  1, 1, 5'b00010, 1, 1, 1); // 50
      addVec(1, 0, 0, 1, 0, 5'b00000,  0, 0, 5'b00000, 0, 0, 0); // reset during launch
      addVec(0, 0, 0, 0, 0, 5'b00000,  0, 0, 5'b00000, 0, 0, 0);
      addVec(0, 0, 0, 0, 0, 5'b11111,  0, 0, 5'b00000, 0, 0, 0); // done ignored in menu
      addVec(0, 0, 0, 0, 0, 5'b00000,  0, 0, 5'b00000, 0, 0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec[%0d]", i));
      end

      // Launch latency: confirm edge should yield mode_start on the very next cycle.
      @(negedge clk);
      confirm = 1'b1;
      lat = -1;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk);
         #1;
         if (mode_start) begin
            lat = i;
            break;
         end
      end
      checkValue("launch_latency", lat, 1);
      checkValue("launch_mode_en", int'(mode_en), 1);

      @(negedge clk);
      confirm = 1'b0;
      @(posedge clk);
      #1;
      checkValue("run_start_low", int'(mode_start), 0);
      checkValue("run_busy", int'(busy), 1);

      @(negedge clk);
      mode_done = 5'b00010;
      @(posedge clk);
      #1;
      checkValue("run_foreign_done", int'(mode_en), 1);

      @(negedge clk);
      mode_done = 5'b00001;
      @(posedge clk);
      #1;
      @(negedge clk);
      mode_done = '0;
      exit_len = 0;
      for (int i = 0; i < 10; i++) begin
         if (!busy) break;
         if (mode_en == '0 && disp_sel) exit_len++;
         @(posedge clk);
         #1;
      end
      checkValue("exit_length", exit_len, 2);
      checkValue("exit_menu_disp", int'(disp_sel), 0);
      checkValue("exit_menu_cursor", int'(cursor), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
